// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pkg
//  Purpose  : Shared types and constants for the round-robin grant scheduler.
//             Holds the FSM state enum, requester count, index width, the
//             "no request" index value and a one-hot helper.
//  Revision : 1.0  initial release
// ============================================================================
package rr_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  // Index driven whenever no grant is active.
  localparam logic [IDX_W-1:0] IDX_NONE = 4'd0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_sched_prio_enc16.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc16
//  Purpose  : Combinational highest-set-bit encoder over 16 lines.
//  Ports    : in_i  [15:0] candidate vector
//             idx_o [3:0]  index of the highest set bit (0 when none)
//             any_o        at least one bit of in_i is set
//  Revision : 1.0  initial release
// ============================================================================
module prio_enc16
  import rr_pkg::*;
(
  input  logic [N_REQ-1:0] in_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the
  // highest set bit wins.
  always_comb begin
    idx_o = IDX_NONE;
    for (int i = 0; i < N_REQ; i++) begin
      if (in_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o = |in_i;

endmodule
`default_nettype wire

// File: rtl/rr_grant_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_sched
//  Purpose  : 16-requester round-robin arbiter. Masks the request vector,
//             ranks the last winner lowest, picks one owner with a
//             highest-bit-wins encoder and holds the grant until the owner
//             releases or a hold watchdog forces a revoke.
//  Ports    : clk           rising-edge clock
//             rst           synchronous reset, active-high
//             req_i  [15:0] level-sensitive request lines
//             mask_i [15:0] per-requester enable, 1 = may be granted
//             release_i     owner done (only looked at while a grant is held)
//             grant_o [15:0] registered one-hot grant
//             grant_idx_o [3:0] registered binary owner index
//             grant_valid_o registered "grant active"
//             timeout_o     one-cycle pulse on forced revoke
//  Revision : 1.0  initial release
// ============================================================================
module rr_grant_sched
  import rr_pkg::*;
#(
  parameter int MAX_HOLD = 200   // legal range 2..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic             release_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o,
  output logic             timeout_o
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [7:0]       hold_cnt_q;
  logic [7:0]       hold_cnt_d;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic             grant_valid_q;
  logic             timeout_q;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] below_ptr;
  logic [N_REQ-1:0] low;
  logic [IDX_W-1:0] low_idx;
  logic             low_any;
  logic [IDX_W-1:0] elig_idx;
  logic             elig_any;
  logic [IDX_W-1:0] winner_d;

  assign elig      = req_i & mask_i;
  // Bits strictly below the last winner; empty when ptr is 0.
  assign below_ptr = (N_REQ'(1) << ptr_q) - N_REQ'(1);
  assign low       = elig & below_ptr;

  prio_enc16 u_enc_low (
    .in_i  (low),
    .idx_o (low_idx),
    .any_o (low_any)
  );

  prio_enc16 u_enc_elig (
    .in_i  (elig),
    .idx_o (elig_idx),
    .any_o (elig_any)
  );

  // Prefer the highest requester below the last winner; otherwise wrap to
  // the highest requester overall, which leaves the last winner ranked last.
  assign winner_d   = low_any ? low_idx : elig_idx;
  assign hold_cnt_d = hold_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= IDX_NONE;
      hold_cnt_q    <= 8'd0;
      grant_q       <= '0;
      grant_idx_q   <= IDX_NONE;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (elig_any) begin
            state_q       <= ST_GRANT;
            grant_q       <= idx_to_onehot(winner_d);
            grant_idx_q   <= winner_d;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= 8'd0;
          end
        end
        ST_GRANT: begin
          // Release takes priority over watchdog expiry in the same cycle.
          if (release_i || (hold_cnt_q == HOLD_LAST)) begin
            state_q       <= ST_IDLE;
            ptr_q         <= grant_idx_q;
            grant_q       <= '0;
            grant_idx_q   <= IDX_NONE;
            grant_valid_q <= 1'b0;
            timeout_q     <= ~release_i;
          end
          hold_cnt_q <= hold_cnt_d;
        end
        default: begin
          state_q       <= ST_IDLE;
          grant_q       <= '0;
          grant_idx_q   <= IDX_NONE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_grant_sched
//  Purpose  : Self-checking bench for rr_grant_sched (MAX_HOLD = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_grant_sched;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] mask;
  logic        rel;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner is -1 when nothing is granted; held counts the
  // grant_valid cycles seen so far for the current owner.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] mask;
    logic        rel;
    logic [15:0] e_grant;
    logic [3:0]  e_idx;
    logic        e_valid;
    logic        e_to;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_grant_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .mask_i        (mask),
    .release_i     (rel),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .timeout_o     (timeout)
  );

  // Walk the rotation order k-1, k-2, ..., 0, 15, ..., k and take the first
  // eligible requester.
  function automatic int pick(input logic [15:0] e, input int p);
    for (int k = 1; k <= 16; k++) begin
      int c;
      c = (p - k + 16) % 16;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        m_owner = pick(req & mask, m_ptr);
        m_held  = 1;
      end else if (rel) begin
        m_ptr = m_owner; m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        m_ptr = m_owner; m_owner = -1; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [21:0] model_out();
    if (m_owner < 0) return {16'h0, 4'h0, 1'b0, m_to};
    return {16'h1 << m_owner, 4'(m_owner), 1'b1, m_to};
  endfunction

  function automatic logic [21:0] dut_out();
    return {grant, grant_idx, grant_valid, timeout};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got grant=%h idx=%0d valid=%b to=%b, want grant=%h idx=%0d valid=%b to=%b",
               name, $time, act[21:6], act[5:2], act[1], act[0], exp[21:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs in force, then compare.
  task automatic cyc(input string name);
    model_step();
    @(posedge clk);
    #1;
    check(name, dut_out(), model_out());
  endtask

  task automatic add(input logic r, input logic [15:0] rq, input logic [15:0] mk, input logic rl,
                     input logic [15:0] eg, input logic [3:0] ei, input logic ev, input logic et);
    tbl.push_back('{r, rq, mk, rl, eg, ei, ev, et});
  endtask

  initial begin
    rst = 1'b1; req = 16'h0; mask = 16'h0; rel = 1'b0;

    // ---------------- table-driven vectors ----------------
    // 8001 alternation, release in the third grant cycle.
    add(1, 16'h0000, 16'hFFFF, 0, 16'h0000,  0, 0, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h8000, 15, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h8000, 15, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h8000, 15, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 1, 16'h0000,  0, 0, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h0001,  0, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h0001,  0, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h0001,  0, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 1, 16'h0000,  0, 0, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h8000, 15, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h8000, 15, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h8000, 15, 1, 0);
    add(0, 16'h8001, 16'hFFFF, 1, 16'h0000,  0, 0, 0);
    add(0, 16'h8001, 16'hFFFF, 0, 16'h0001,  0, 1, 0);
    // Mask 7FFF: only idx 2 eligible; clearing its mask/req keeps the grant.
    add(1, 16'h8004, 16'h7FFF, 0, 16'h0000,  0, 0, 0);
    add(0, 16'h8004, 16'h7FFF, 0, 16'h0004,  2, 1, 0);
    add(0, 16'h8004, 16'h7FFB, 0, 16'h0004,  2, 1, 0);
    add(0, 16'h0000, 16'h7FFB, 0, 16'h0004,  2, 1, 0);
    add(0, 16'h8004, 16'h7FFB, 1, 16'h0000,  0, 0, 0);
    add(0, 16'h8004, 16'h7FFB, 0, 16'h0000,  0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; mask = tbl[i].mask; rel = tbl[i].rel;
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), dut_out(),
            {tbl[i].e_grant, tbl[i].e_idx, tbl[i].e_valid, tbl[i].e_to});
    end

    // ---------------- full rotation, one dead cycle between owners ----------------
    rst = 1'b1; req = 16'hFFFF; mask = 16'hFFFF; rel = 1'b0;
    cyc("rot_rst");
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      cyc("rot_grant");
      check_int("rot_idx", int'(grant_idx), (15 - k + 16) % 16);
      check_int("rot_valid", int'(grant_valid), 1);
      rel = 1'b1;
      cyc("rot_dead");
      check_int("rot_dead_valid", int'(grant_valid), 0);
      rel = 1'b0;
    end

    // ---------------- watchdog timeout ----------------
    rst = 1'b1; req = 16'h0010; mask = 16'hFFFF; rel = 1'b0;
    cyc("to_rst");
    rst = 1'b0;
    for (int i = 0; i < MAX_HOLD; i++) begin
      cyc("to_hold");
      check("to_hold_exp", dut_out(), {16'h0010, 4'd4, 1'b1, 1'b0});
    end
    cyc("to_pulse");
    check("to_pulse_exp", dut_out(), {16'h0000, 4'd0, 1'b0, 1'b1});
    cyc("to_regrant");
    check("to_regrant_exp", dut_out(), {16'h0010, 4'd4, 1'b1, 1'b0});

    // ---------------- release coincides with expiry ----------------
    rst = 1'b1; req = 16'h0010; rel = 1'b0;
    cyc("rx_rst");
    rst = 1'b0;
    for (int i = 0; i < MAX_HOLD; i++) cyc("rx_hold");
    rel = 1'b1; req = 16'h0018;
    cyc("rx_release");
    check("rx_release_exp", dut_out(), {16'h0000, 4'd0, 1'b0, 1'b0});
    rel = 1'b0;
    cyc("rx_ptr");
    check("rx_ptr_exp", dut_out(), {16'h0008, 4'd3, 1'b1, 1'b0});

    // ---------------- reset while granted ----------------
    rst = 1'b1; req = 16'h0200; rel = 1'b0;
    cyc("rg_rst");
    rst = 1'b0;
    cyc("rg_g1");
    rel = 1'b1;
    cyc("rg_rel");
    rel = 1'b0;
    cyc("rg_g2");
    check("rg_g2_exp", dut_out(), {16'h0200, 4'd9, 1'b1, 1'b0});
    rst = 1'b1;
    cyc("rg_midrst");
    check("rg_midrst_exp", dut_out(), {16'h0000, 4'd0, 1'b0, 1'b0});
    rst = 1'b0; req = 16'h0300;
    cyc("rg_after");
    check("rg_after_exp", dut_out(), {16'h0200, 4'd9, 1'b1, 1'b0});

    // ---------------- randomized against the model ----------------
    rst = 1'b1; rel = 1'b0;
    cyc("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) req = req & 16'($urandom);
      mask = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
      rel  = ($urandom_range(0, 3) == 0);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
